// File: rtl/sprite_rom_arbiter.sv
// ---------------------------------------------------------------------------
// sprite_rom_arbiter
//
// Lets up to NUM_REQ pixel renderers (score digits, tanks, HUD, ...) share one
// single-port sprite frame ROM. The ROM has one cycle of read latency and a
// registered RGB output. One requester is granted per clock in round-robin
// order. Its address is registered onto the shared ROM address bus, and the
// returned word is handed back to the same requester three register edges
// later: the transfer edge, the ROM's own output edge and the response edge.
// The block never stalls, so grant does not depend on pipeline occupancy.
//
// Ports
//   Clk        in   system clock, rising edge
//   Reset_n    in   asynchronous active-low reset
//   req        in   [NUM_REQ]          per-requester fetch valid
//   req_addr   in   [NUM_REQ*ADDR_W]   requester i at [i*ADDR_W +: ADDR_W]
//   grant      out  [NUM_REQ]          combinational one-hot ready
//   rom_addr   out  [ADDR_W]           registered ROM read address
//   rom_data   in   [DATA_W]           registered ROM output
//   rsp_valid  out  [NUM_REQ]          registered one-hot owner of rsp_data
//   rsp_data   out  [DATA_W]           registered returned pixel
//   busy       out                     a fetch is somewhere in the pipeline
//
// NUM_REQ is meant to lie in 2..8.
// ---------------------------------------------------------------------------
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 24
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        grant,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Requester id to one-hot response lane.
  function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [PTR_W-1:0] id);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (id == PTR_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Round-robin successor; wraps explicitly so non-power-of-two NUM_REQ works.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] w);
    if (w == PTR_W'(NUM_REQ - 1)) return '0;
    return w + 1'b1;
  endfunction

  // Highest-priority requester.
  logic [PTR_W-1:0]  ptr;

  logic              vld_p0;
  logic [PTR_W-1:0]  id_p0;
  logic [ADDR_W-1:0] addr_p0;

  logic              vld_p1;
  logic [PTR_W-1:0]  id_p1;

  logic              vld_p2;
  logic [PTR_W-1:0]  id_p2;

  // ---- stage p0: combinational arbitration, scan from ptr upward with wrap
  always_comb begin
    int idx;
    idx    = 0;
    grant  = '0;
    vld_p0 = 1'b0;
    id_p0  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!vld_p0 && req[idx]) begin
        vld_p0     = 1'b1;
        id_p0      = PTR_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  assign addr_p0 = req_addr[int'(id_p0)*ADDR_W +: ADDR_W];

  // ---- stage p1: transfer edge, address driven to the ROM
  // rom_addr holds through idle cycles so the ROM input does not toggle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr      <= '0;
      rom_addr <= '0;
      vld_p1   <= 1'b0;
      id_p1    <= '0;
    end else if (vld_p0) begin
      ptr      <= next_ptr(id_p0);
      rom_addr <= addr_p0;
      vld_p1   <= 1'b1;
      id_p1    <= id_p0;
    end else begin
      vld_p1   <= 1'b0;
    end
  end

  // ---- stage p2: shadows the ROM output register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_p2 <= 1'b0;
      id_p2  <= '0;
    end else begin
      vld_p2 <= vld_p1;
      id_p2  <= id_p1;
    end
  end

  // ---- response stage: capture ROM word and steer it to its owner
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= vld_p2 ? id_to_onehot(id_p2) : '0;
      if (vld_p2) rsp_data <= rom_data;
    end
  end

  assign busy = vld_p1 | vld_p2 | (|rsp_valid);

endmodule
